// File: rtl/forwarding_unit_pkg.sv
// forwarding_unit_pkg
// Types shared by the forwarding unit and the blocks that feed it.
// forwarding_type_t is the forwarding class of an instruction. It tells the
// forwarding unit where that instruction consumes its source operands.
package forwarding_unit_pkg;

    typedef enum logic [1:0] {
        NoForward            = 2'd0,
        ForwardExecute       = 2'd1,
        ForwardExecuteMemory = 2'd2,
        ForwardDecode        = 2'd3
    } forwarding_type_t;

endpackage

// File: rtl/pipeline_tracker_pkg.sv
// pipeline_tracker_pkg
// Holds the per-stage record that follows an instruction through EX, MEM and
// WB, and the bubble value that a stage loads when it is squashed.
package pipeline_tracker_pkg;

    import forwarding_unit_pkg::*;

    localparam int RegAddrW = 5;

    typedef struct packed {
        logic [RegAddrW-1:0] rd;
        logic [RegAddrW-1:0] rs1;
        logic [RegAddrW-1:0] rs2;
        logic                reg_we;
        logic                mem_read;
        forwarding_type_t    forwarding_type;
    } stage_info_t;

    localparam stage_info_t BubbleStage = '{
        rd:              '0,
        rs1:             '0,
        rs2:             '0,
        reg_we:          1'b0,
        mem_read:        1'b0,
        forwarding_type: NoForward
    };

endpackage

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg
// One pipeline stage record register.
//   clock  : pipeline clock
//   reset  : asynchronous active-low reset (loads BUBBLE)
//   hold   : keep the current contents (highest priority)
//   bubble : load BUBBLE instead of d
//   d      : record from the previous stage
//   q      : registered record
module pipeline_stage_reg
    import pipeline_tracker_pkg::*;
#(
    parameter type T      = stage_info_t,
    parameter T    BUBBLE = BubbleStage
) (
    input  logic clock,
    input  logic reset,
    input  logic hold,
    input  logic bubble,
    input  T     d,
    output T     q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q <= BUBBLE;
        end else if (hold) begin
            q <= q;
        end else if (bubble) begin
            q <= BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_tracker.sv
// pipeline_tracker
// Tracks rd/rs/write-enable/load/forwarding-class metadata of in-flight
// instructions through EX, MEM and WB. It also generates the load-use stall
// for ID and inserts the matching bubble into EX.
// Ports:
//   clock, reset (async, active-low)
//   ID inputs : rs1_id, rs2_id, rd_id, reg_we_id, mem_read_id,
//               forwarding_type_id, flush_id
//   stall_mem : freezes every stage register
//   outputs   : per-stage rd/reg_we/rs/forwarding_type/mem_read,
//               stall_id (combinational)
// Optional build macro PIPELINE_TRACKER_STATS_EN adds the 32-bit counters
// load_use_stalls and flush_count.
module pipeline_tracker
    import forwarding_unit_pkg::*;
    import pipeline_tracker_pkg::*;
#(
    parameter int N = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     rs1_id,
    input  logic [N-1:0]     rs2_id,
    input  logic [N-1:0]     rd_id,
    input  logic             reg_we_id,
    input  logic             mem_read_id,
    input  forwarding_type_t forwarding_type_id,
    input  logic             flush_id,
    input  logic             stall_mem,
    output logic [N-1:0]     rd_ex,
    output logic [N-1:0]     rd_mem,
    output logic [N-1:0]     rd_wb,
    output logic             reg_we_ex,
    output logic             reg_we_mem,
    output logic             reg_we_wb,
    output logic [N-1:0]     rs1_ex,
    output logic [N-1:0]     rs2_ex,
    output logic [N-1:0]     rs2_mem,
    output forwarding_type_t forwarding_type_ex,
    output forwarding_type_t forwarding_type_mem,
    output logic             mem_read_ex,
    output logic             mem_read_mem,
`ifdef PIPELINE_TRACKER_STATS_EN
    output logic [31:0]      load_use_stalls,
    output logic [31:0]      flush_count,
`endif
    output logic             stall_id
);

    stage_info_t id_rec;
    stage_info_t ex_q;
    stage_info_t mem_q;
    stage_info_t wb_q;
    logic        ld_ex;
    logic        ld_mem;
    logic        hazard_ex;
    logic        hazard_mem;

    always_comb begin
        id_rec                 = BubbleStage;
        id_rec.rd              = rd_id;
        id_rec.rs1             = rs1_id;
        id_rec.rs2             = rs2_id;
        id_rec.reg_we          = reg_we_id;
        id_rec.mem_read        = mem_read_id;
        id_rec.forwarding_type = forwarding_type_id;
    end

    // A stage only counts as a pending load if it writes a real register.
    assign ld_ex  = ex_q.mem_read  & ex_q.reg_we  & (ex_q.rd  != '0);
    assign ld_mem = mem_q.mem_read & mem_q.reg_we & (mem_q.rd != '0);

    // Store data (rs2) under ForwardExecuteMemory is picked up at MEM, so a
    // load in EX does not have to stall it.
    assign hazard_ex = ld_ex & ((ex_q.rd == rs1_id) |
                       ((ex_q.rd == rs2_id) & (forwarding_type_id != ForwardExecuteMemory)));

    // Decode-stage consumers (branches) also need to wait out a load in MEM.
    assign hazard_mem = (forwarding_type_id == ForwardDecode) & ld_mem &
                        ((mem_q.rd == rs1_id) | (mem_q.rd == rs2_id));

    assign stall_id = ~flush_id & (hazard_ex | hazard_mem);

    pipeline_stage_reg u_ex_reg (
        .clock  (clock),
        .reset  (reset),
        .hold   (stall_mem),
        .bubble (stall_id | flush_id),
        .d      (id_rec),
        .q      (ex_q)
    );

    pipeline_stage_reg u_mem_reg (
        .clock  (clock),
        .reset  (reset),
        .hold   (stall_mem),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    pipeline_stage_reg u_wb_reg (
        .clock  (clock),
        .reset  (reset),
        .hold   (stall_mem),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    assign rd_ex               = ex_q.rd;
    assign rd_mem              = mem_q.rd;
    assign rd_wb               = wb_q.rd;
    assign reg_we_ex           = ex_q.reg_we;
    assign reg_we_mem          = mem_q.reg_we;
    assign reg_we_wb           = wb_q.reg_we;
    assign rs1_ex              = ex_q.rs1;
    assign rs2_ex              = ex_q.rs2;
    assign rs2_mem             = mem_q.rs2;
    assign forwarding_type_ex  = ex_q.forwarding_type;
    assign forwarding_type_mem = mem_q.forwarding_type;
    assign mem_read_ex         = ex_q.mem_read;
    assign mem_read_mem        = mem_q.mem_read;

`ifdef PIPELINE_TRACKER_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_use_stalls <= '0;
            flush_count     <= '0;
        end else if (!stall_mem) begin
            if (stall_id) load_use_stalls <= load_use_stalls + 32'd1;
            if (flush_id) flush_count     <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_tracker.sv
module tb_pipeline_tracker;
    import forwarding_unit_pkg::*;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       rs1_id = '0, rs2_id = '0, rd_id = '0;
    logic             reg_we_id = 1'b0, mem_read_id = 1'b0;
    forwarding_type_t forwarding_type_id = NoForward;
    logic             flush_id = 1'b0, stall_mem = 1'b0;
    logic [4:0]       rd_ex, rd_mem, rd_wb, rs1_ex, rs2_ex, rs2_mem;
    logic             reg_we_ex, reg_we_mem, reg_we_wb, mem_read_ex, mem_read_mem;
    forwarding_type_t forwarding_type_ex, forwarding_type_mem;
    logic             stall_id;
`ifdef PIPELINE_TRACKER_STATS_EN
    logic [31:0]      load_use_stalls, flush_count;
    int               saved_ls, saved_fl;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    always #5 clock = ~clock;

    pipeline_tracker #(.N(5)) dut (
        .clock(clock), .reset(reset),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .reg_we_id(reg_we_id), .mem_read_id(mem_read_id),
        .forwarding_type_id(forwarding_type_id),
        .flush_id(flush_id), .stall_mem(stall_mem),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .reg_we_ex(reg_we_ex), .reg_we_mem(reg_we_mem), .reg_we_wb(reg_we_wb),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rs2_mem(rs2_mem),
        .forwarding_type_ex(forwarding_type_ex),
        .forwarding_type_mem(forwarding_type_mem),
        .mem_read_ex(mem_read_ex), .mem_read_mem(mem_read_mem),
`ifdef PIPELINE_TRACKER_STATS_EN
        .load_use_stalls(load_use_stalls), .flush_count(flush_count),
`endif
        .stall_id(stall_id)
    );

    // Model: a three-entry list of in-flight instructions, index 0 = EX.
    typedef struct {
        int  rd, rs1, rs2;
        bit  we, mr;
        int  ft;
    } rec_t;

    rec_t m_pipe [3];
    int   m_ls, m_fl;

    function automatic rec_t bubble_rec();
        rec_t r;
        r.rd = 0; r.rs1 = 0; r.rs2 = 0; r.we = 0; r.mr = 0; r.ft = int'(NoForward);
        return r;
    endfunction

    function automatic bit is_load(rec_t r);
        return r.mr && r.we && r.rd != 0;
    endfunction

    function automatic bit m_stall();
        bit s;
        int r1, r2, ft;
        r1 = int'(rs1_id); r2 = int'(rs2_id); ft = int'(forwarding_type_id);
        s = 0;
        if (is_load(m_pipe[0]) && m_pipe[0].rd == r1) s = 1;
        if (is_load(m_pipe[0]) && m_pipe[0].rd == r2 && ft != int'(ForwardExecuteMemory)) s = 1;
        if (ft == int'(ForwardDecode) && is_load(m_pipe[1]) &&
            (m_pipe[1].rd == r1 || m_pipe[1].rd == r2)) s = 1;
        if (flush_id) s = 0;
        return s;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) m_pipe[i] <= bubble_rec();
            m_ls <= 0;
            m_fl <= 0;
        end else if (!stall_mem) begin
            rec_t id;
            id.rd = int'(rd_id); id.rs1 = int'(rs1_id); id.rs2 = int'(rs2_id);
            id.we = reg_we_id; id.mr = mem_read_id; id.ft = int'(forwarding_type_id);
            m_pipe[2] <= m_pipe[1];
            m_pipe[1] <= m_pipe[0];
            m_pipe[0] <= (m_stall() || flush_id) ? bubble_rec() : id;
            if (m_stall()) m_ls <= m_ls + 1;
            if (flush_id) m_fl <= m_fl + 1;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (checking) begin
            chk("m.rd_ex",   int'(rd_ex),   m_pipe[0].rd);
            chk("m.rd_mem",  int'(rd_mem),  m_pipe[1].rd);
            chk("m.rd_wb",   int'(rd_wb),   m_pipe[2].rd);
            chk("m.we_ex",   int'(reg_we_ex),  int'(m_pipe[0].we));
            chk("m.we_mem",  int'(reg_we_mem), int'(m_pipe[1].we));
            chk("m.we_wb",   int'(reg_we_wb),  int'(m_pipe[2].we));
            chk("m.rs1_ex",  int'(rs1_ex),  m_pipe[0].rs1);
            chk("m.rs2_ex",  int'(rs2_ex),  m_pipe[0].rs2);
            chk("m.rs2_mem", int'(rs2_mem), m_pipe[1].rs2);
            chk("m.ft_ex",   int'(forwarding_type_ex),  m_pipe[0].ft);
            chk("m.ft_mem",  int'(forwarding_type_mem), m_pipe[1].ft);
            chk("m.mr_ex",   int'(mem_read_ex),  int'(m_pipe[0].mr));
            chk("m.mr_mem",  int'(mem_read_mem), int'(m_pipe[1].mr));
            chk("m.stall_id", int'(stall_id), int'(m_stall()));
`ifdef PIPELINE_TRACKER_STATS_EN
            chk("m.load_use_stalls", int'(load_use_stalls), m_ls);
            chk("m.flush_count",     int'(flush_count),     m_fl);
`endif
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd, input bit we,
                         input bit mr, input forwarding_type_t ft);
        rs1_id = 5'(rs1); rs2_id = 5'(rs2); rd_id = 5'(rd);
        reg_we_id = we; mem_read_id = mr; forwarding_type_id = ft;
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, NoForward);
    endtask

    initial begin
        // Reset with random ID inputs
        reset = 1'b0;
        checking = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(31), $urandom_range(31), $urandom_range(31),
                  1'($urandom), 1'($urandom), forwarding_type_t'($urandom_range(3)));
            stall_mem = 1'($urandom);
            tick();
        end
        chk("rst.rd_ex", int'(rd_ex), 0);
        chk("rst.we_wb", int'(reg_we_wb), 0);
        chk("rst.ft_mem", int'(forwarding_type_mem), int'(NoForward));
        chk("rst.stall_id", int'(stall_id), 0);
        stall_mem = 1'b0;
        drive(0, 0, 5, 1, 0, ForwardExecute);
        reset = 1'b1;
        tick();
        nop();
        chk("lat.rd_ex", int'(rd_ex), 5);
        tick();
        chk("lat.rd_mem", int'(rd_mem), 5);
        tick();
        chk("lat.rd_wb", int'(rd_wb), 5);

        // Load-use in EX
        drive(1, 0, 7, 1, 1, ForwardExecute);
        tick();
        drive(7, 0, 8, 1, 0, ForwardExecute);
        chk("lu.stall", int'(stall_id), 1);
        tick();
        chk("lu.we_ex", int'(reg_we_ex), 0);
        chk("lu.mr_mem", int'(mem_read_mem), 1);
        chk("lu.rd_mem", int'(rd_mem), 7);
        chk("lu.stall_after", int'(stall_id), 0);
        tick();
        nop();
        chk("lu.rd_ex", int'(rd_ex), 8);
        tick();

        // Store exemption
        drive(1, 0, 7, 1, 1, ForwardExecute);
        tick();
        drive(2, 7, 0, 0, 0, ForwardExecuteMemory);
        chk("st.stall", int'(stall_id), 0);
        tick();
        nop();
        tick();
        chk("st.rs2_mem", int'(rs2_mem), 7);
        chk("st.rd_wb", int'(rd_wb), 7);
        chk("st.we_wb", int'(reg_we_wb), 1);
        tick();

        // ForwardDecode behind a load: two stall cycles
        drive(1, 0, 9, 1, 1, ForwardExecute);
        tick();
        drive(9, 0, 0, 0, 0, ForwardDecode);
        chk("fd.stall1", int'(stall_id), 1);
        tick();
        chk("fd.stall2", int'(stall_id), 1);
        tick();
        chk("fd.stall3", int'(stall_id), 0);
        tick();
        drive(1, 0, 9, 1, 0, ForwardExecute);
        tick();
        drive(9, 0, 0, 0, 0, ForwardDecode);
        chk("fd.alu_stall", int'(stall_id), 0);
        tick();
        nop();
        tick();

        // stall_mem takes precedence over the load-use bubble
        drive(1, 0, 7, 1, 1, ForwardExecute);
        tick();
        drive(7, 0, 3, 1, 0, ForwardExecute);
        stall_mem = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sm.stall", int'(stall_id), 1);
            chk("sm.rd_ex", int'(rd_ex), 7);
            chk("sm.mr_ex", int'(mem_read_ex), 1);
            tick();
        end
        stall_mem = 1'b0;
        #1;
        chk("sm.stall_rel", int'(stall_id), 1);
        tick();
        chk("sm.bubble_we", int'(reg_we_ex), 0);
        chk("sm.rd_mem", int'(rd_mem), 7);
        chk("sm.stall_clr", int'(stall_id), 0);
        tick();
        nop();
        chk("sm.alu_ex", int'(rd_ex), 3);
        tick();

        // Flush beats a hazard
        drive(1, 0, 7, 1, 1, ForwardExecute);
        tick();
        drive(7, 0, 4, 1, 0, ForwardExecute);
        flush_id = 1'b1;
        #1;
        chk("fl.stall", int'(stall_id), 0);
`ifdef PIPELINE_TRACKER_STATS_EN
        saved_ls = int'(load_use_stalls);
        saved_fl = int'(flush_count);
`endif
        tick();
        flush_id = 1'b0;
        nop();
        chk("fl.rd_ex", int'(rd_ex), 0);
        chk("fl.we_ex", int'(reg_we_ex), 0);
        chk("fl.rd_mem", int'(rd_mem), 7);
`ifdef PIPELINE_TRACKER_STATS_EN
        chk("fl.flush_count", int'(flush_count), saved_fl + 1);
        chk("fl.load_use_stalls", int'(load_use_stalls), saved_ls);
`endif
        tick();

        // Reset asserted mid-stall
        drive(1, 0, 7, 1, 1, ForwardExecute);
        tick();
        drive(7, 0, 4, 1, 0, ForwardExecute);
        chk("rs.stall_before", int'(stall_id), 1);
        reset = 1'b0;
        #1;
        chk("rs.stall_after", int'(stall_id), 0);
        chk("rs.rd_ex", int'(rd_ex), 0);
        chk("rs.mr_ex", int'(mem_read_ex), 0);
        tick();
        reset = 1'b1;
        nop();
        tick();
        tick();

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
